// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: groups the two requester handshakes and the ROM pins.
//
// Handshake: a requester raises REQ_x with ADDR_x and holds both stable until
// it sees GNT_x high in the same cycle. The read completes two rising edges
// after the grant: DATA_x is updated and VALID_x pulses high for one cycle.
// REQ_x may stay high after a grant to issue another read the next cycle.
//
// Modports:
//   slave  - the arbiter: sees requests and ROM data, drives grants/data/ROM pins
//   master - the environment (requesters + ROM): the mirror image
interface rom_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          REQ_A;
  logic [AW-1:0] ADDR_A;
  logic          GNT_A;
  logic          VALID_A;
  logic [DW-1:0] DATA_A;
  logic          REQ_B;
  logic [AW-1:0] ADDR_B;
  logic          GNT_B;
  logic          VALID_B;
  logic [DW-1:0] DATA_B;
  logic          ROM_nCS;
  logic [AW-1:0] ROM_ADDR;
  logic [DW-1:0] ROM_DO;

  modport slave (
    input  REQ_A, ADDR_A, REQ_B, ADDR_B, ROM_DO,
    output GNT_A, VALID_A, DATA_A, GNT_B, VALID_B, DATA_B, ROM_nCS, ROM_ADDR
  );

  modport master (
    output REQ_A, ADDR_A, REQ_B, ADDR_B, ROM_DO,
    input  GNT_A, VALID_A, DATA_A, GNT_B, VALID_B, DATA_B, ROM_nCS, ROM_ADDR
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one single-port synchronous ROM between port A (CPU
// fetch) and port B (secondary master). One ROM read per cycle at most; read
// data is steered back to the port that won the grant.
//
// Ports:
//   CLK       - system clock, rising edge
//   nRESET    - asynchronous active-low reset
//   bus       - rom_arbiter_if.slave: requests, grants, per-port data/valid,
//               ROM chip select / address / data
//   dbg_owner - current owner tag of the read in flight (0 none, 1 A, 2 B)
//
// Timing: grant in cycle N (combinational), ROM samples address at edge N,
// ROM_DO valid in cycle N+1, DATA_x/VALID_x registered at edge N+1.
module rom_arbiter #(
  parameter int RR_MODE      = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 12,
  parameter int DW           = 16
) (
  input  logic          CLK,
  input  logic          nRESET,
  rom_arbiter_if.slave  bus,
  output logic [1:0]    dbg_owner
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_t        owner;
  logic          last_b;      // 1 when B won the most recent grant
  logic [3:0]    starve_cnt;  // consecutive A grants while B was waiting
  logic          gnt_a;
  logic          gnt_b;
  logic          valid_a;
  logic          valid_b;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;

  // Grant decision. Held at zero while in reset so the ROM is never selected.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (nRESET) begin
      if (bus.REQ_A && bus.REQ_B) begin
        if (RR_MODE != 0) begin
          gnt_a = last_b;
          gnt_b = !last_b;
        end else if (starve_cnt == LIMIT) begin
          gnt_b = 1'b1;
        end else begin
          gnt_a = 1'b1;
        end
      end else begin
        gnt_a = bus.REQ_A;
        gnt_b = bus.REQ_B;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      owner      <= OWN_NONE;
      last_b     <= 1'b1;
      starve_cnt <= 4'd0;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
      data_a     <= '0;
      data_b     <= '0;
    end else begin
      // Single-stage owner tag: overwritten every cycle, which is enough
      // because ROM data always returns exactly one cycle after the grant.
      if (gnt_a)      owner <= OWN_A;
      else if (gnt_b) owner <= OWN_B;
      else            owner <= OWN_NONE;

      if (gnt_a) last_b <= 1'b0;
      if (gnt_b) last_b <= 1'b1;

      if (gnt_b || !bus.REQ_B)                starve_cnt <= 4'd0;
      else if (gnt_a && starve_cnt != LIMIT)  starve_cnt <= starve_cnt + 4'd1;

      valid_a <= 1'b0;
      valid_b <= 1'b0;
      case (owner)
        OWN_A: begin
          data_a  <= bus.ROM_DO;
          valid_a <= 1'b1;
        end
        OWN_B: begin
          data_b  <= bus.ROM_DO;
          valid_b <= 1'b1;
        end
        default: ;  // none or unused encoding: no data captured
      endcase
    end
  end

  assign bus.GNT_A    = gnt_a;
  assign bus.GNT_B    = gnt_b;
  assign bus.ROM_nCS  = !(gnt_a || gnt_b);
  assign bus.ROM_ADDR = gnt_b ? bus.ADDR_B : bus.ADDR_A;
  assign bus.VALID_A  = valid_a;
  assign bus.VALID_B  = valid_b;
  assign bus.DATA_A   = data_a;
  assign bus.DATA_B   = data_b;
  assign dbg_owner    = owner;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: one round-robin and one fixed-priority
// instance share the clock and reset; each has its own ROM model where
// ROM[a] = 16'h8000 ^ (a * 16'h0101).
module tb_rom_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] own_rr;
  logic [1:0] own_fp;
  int         checks;
  int         errors;

  rom_arbiter_if #(.AW(AW), .DW(DW)) bus_rr ();
  rom_arbiter_if #(.AW(AW), .DW(DW)) bus_fp ();

  rom_arbiter #(.RR_MODE(1), .STARVE_LIMIT(4), .AW(AW), .DW(DW)) u_rr (
    .CLK(clk), .nRESET(rst_n), .bus(bus_rr.slave), .dbg_owner(own_rr)
  );

  rom_arbiter #(.RR_MODE(0), .STARVE_LIMIT(4), .AW(AW), .DW(DW)) u_fp (
    .CLK(clk), .nRESET(rst_n), .bus(bus_fp.slave), .dbg_owner(own_fp)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM models: registered output one cycle after chip select
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = {4'd0, a};
    return 16'h8000 ^ (w * 16'h0101);
  endfunction

  always @(posedge clk) begin
    if (!bus_rr.ROM_nCS) bus_rr.ROM_DO <= rom_word(bus_rr.ROM_ADDR);
    if (!bus_fp.ROM_nCS) bus_fp.ROM_DO <= rom_word(bus_fp.ROM_ADDR);
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_rr.REQ_A = 1'b0; bus_rr.ADDR_A = '0; bus_rr.REQ_B = 1'b0; bus_rr.ADDR_B = '0;
    bus_fp.REQ_A = 1'b0; bus_fp.ADDR_A = '0; bus_fp.REQ_B = 1'b0; bus_fp.ADDR_B = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bit [5:0] exp_ga6, exp_gb6, exp_va6, exp_vb6;
    bit [7:0] exp_ga8, exp_gb8, exp_va8, exp_vb8;
    checks = 0;
    errors = 0;
    bus_rr.ROM_DO = '0;
    bus_fp.ROM_DO = '0;

    // Reset state
    do_reset();
    settle();
    check("rst_valid_a", 32'(bus_rr.VALID_A), 32'd0);
    check("rst_valid_b", 32'(bus_rr.VALID_B), 32'd0);
    check("rst_data_a",  32'(bus_rr.DATA_A), 32'd0);
    check("rst_data_b",  32'(bus_fp.DATA_B), 32'd0);
    check("rst_ncs",     32'(bus_rr.ROM_nCS), 32'd1);
    check("rst_owner",   32'(own_rr), 32'd0);

    // 1. Single A read at 0x000
    next_cycle();
    bus_rr.REQ_A = 1'b1; bus_rr.ADDR_A = 12'h000;
    settle();
    check("t1_gnt_a_c0", 32'(bus_rr.GNT_A), 32'd1);
    check("t1_gnt_b_c0", 32'(bus_rr.GNT_B), 32'd0);
    check("t1_ncs_c0",   32'(bus_rr.ROM_nCS), 32'd0);
    check("t1_addr_c0",  32'(bus_rr.ROM_ADDR), 32'h000);
    next_cycle();
    bus_rr.REQ_A = 1'b0;
    settle();
    check("t1_valid_c1", 32'(bus_rr.VALID_A), 32'd0);
    check("t1_owner_c1", 32'(own_rr), 32'd1);
    check("t1_ncs_c1",   32'(bus_rr.ROM_nCS), 32'd1);
    next_cycle();
    settle();
    check("t1_valid_c2", 32'(bus_rr.VALID_A), 32'd1);
    check("t1_data_c2",  32'(bus_rr.DATA_A), 32'h8000);
    check("t1_datab_c2", 32'(bus_rr.DATA_B), 32'h0000);
    next_cycle();
    settle();
    check("t1_valid_c3", 32'(bus_rr.VALID_A), 32'd0);
    check("t1_hold_c3",  32'(bus_rr.DATA_A), 32'h8000);

    // 2. Round-robin contention, A first after reset
    do_reset();
    exp_ga6 = 6'b000101; exp_gb6 = 6'b001010;
    exp_va6 = 6'b010100; exp_vb6 = 6'b101000;
    bus_rr.ADDR_A = 12'h004; bus_rr.ADDR_B = 12'h008;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      bus_rr.REQ_A = (c < 4);
      bus_rr.REQ_B = (c < 4);
      settle();
      check($sformatf("t2_gnt_a_c%0d", c), 32'(bus_rr.GNT_A), 32'(exp_ga6[c]));
      check($sformatf("t2_gnt_b_c%0d", c), 32'(bus_rr.GNT_B), 32'(exp_gb6[c]));
      check($sformatf("t2_val_a_c%0d", c), 32'(bus_rr.VALID_A), 32'(exp_va6[c]));
      check($sformatf("t2_val_b_c%0d", c), 32'(bus_rr.VALID_B), 32'(exp_vb6[c]));
      if (c == 1) check("t2_addr_c1", 32'(bus_rr.ROM_ADDR), 32'h008);
      if (c == 2) check("t2_data_a_c2", 32'(bus_rr.DATA_A), 32'h8404);
      if (c == 3) check("t2_data_b_c3", 32'(bus_rr.DATA_B), 32'h8808);
    end

    // 3. Fixed priority with starvation guard, limit 4
    do_reset();
    exp_ga8 = 8'b00101111; exp_gb8 = 8'b00010000;
    exp_va8 = 8'b10111100; exp_vb8 = 8'b01000000;
    bus_fp.ADDR_A = 12'h004; bus_fp.ADDR_B = 12'h008;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      bus_fp.REQ_A = (c < 6);
      bus_fp.REQ_B = (c < 6);
      settle();
      check($sformatf("t3_gnt_a_c%0d", c), 32'(bus_fp.GNT_A), 32'(exp_ga8[c]));
      check($sformatf("t3_gnt_b_c%0d", c), 32'(bus_fp.GNT_B), 32'(exp_gb8[c]));
      check($sformatf("t3_val_a_c%0d", c), 32'(bus_fp.VALID_A), 32'(exp_va8[c]));
      check($sformatf("t3_val_b_c%0d", c), 32'(bus_fp.VALID_B), 32'(exp_vb8[c]));
      if (c == 4) check("t3_addr_c4", 32'(bus_fp.ROM_ADDR), 32'h008);
      if (c == 6) check("t3_data_b_c6", 32'(bus_fp.DATA_B), 32'h8808);
    end

    // 4. Back-to-back A reads at 0,1,2
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      bus_rr.REQ_A  = (c < 3);
      bus_rr.ADDR_A = (c < 3) ? 12'(c) : 12'h000;
      settle();
      check($sformatf("t4_ncs_c%0d", c), 32'(bus_rr.ROM_nCS), (c < 3) ? 32'd0 : 32'd1);
      check($sformatf("t4_val_c%0d", c), 32'(bus_rr.VALID_A), (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
      if (c == 2) check("t4_data_c2", 32'(bus_rr.DATA_A), 32'h8000);
      if (c == 3) check("t4_data_c3", 32'(bus_rr.DATA_A), 32'h8101);
      if (c == 4) check("t4_data_c4", 32'(bus_rr.DATA_A), 32'h8202);
    end

    // 5. Reset while a read is in flight
    next_cycle();
    bus_rr.REQ_A = 1'b1; bus_rr.ADDR_A = 12'h00A;
    settle();
    check("t5_gnt_c0", 32'(bus_rr.GNT_A), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    settle();
    check("t5_rst_valid", 32'(bus_rr.VALID_A), 32'd0);
    check("t5_rst_data",  32'(bus_rr.DATA_A), 32'd0);
    check("t5_rst_gnt",   32'(bus_rr.GNT_A), 32'd0);
    check("t5_rst_ncs",   32'(bus_rr.ROM_nCS), 32'd1);
    next_cycle();
    rst_n = 1'b1;
    bus_rr.REQ_A = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("t5_post_val_%0d", c), 32'(bus_rr.VALID_A), 32'd0);
      check($sformatf("t5_post_dat_%0d", c), 32'(bus_rr.DATA_A), 32'd0);
      next_cycle();
    end
    bus_rr.REQ_A = 1'b1; bus_rr.ADDR_A = 12'h00A;
    settle();
    check("t5_regnt", 32'(bus_rr.GNT_A), 32'd1);
    next_cycle();
    bus_rr.REQ_A = 1'b0;
    next_cycle();
    settle();
    check("t5_reval",  32'(bus_rr.VALID_A), 32'd1);
    check("t5_redata", 32'(bus_rr.DATA_A), 32'h8A0A);

    // 6. Idle for 10 cycles: nothing selected, data held
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      settle();
      check($sformatf("t6_ncs_%0d", c),    32'(bus_rr.ROM_nCS), 32'd1);
      check($sformatf("t6_val_a_%0d", c),  32'(bus_rr.VALID_A), 32'd0);
      check($sformatf("t6_val_b_%0d", c),  32'(bus_rr.VALID_B), 32'd0);
      check($sformatf("t6_data_a_%0d", c), 32'(bus_rr.DATA_A), 32'h8A0A);
      check($sformatf("t6_data_b_%0d", c), 32'(bus_rr.DATA_B), 32'h0000);
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
